// File: rtl/dmem_ctrl_pkg.sv
// Shared types and constants for the byte-serialising data-memory controller.
package dmem_ctrl_pkg;

  localparam int RegW  = 32;
  localparam int ByteW = 8;

  typedef logic [RegW-1:0]  reg_bus_t;
  typedef logic [ByteW-1:0] byte_bus_t;

  localparam reg_bus_t   ZeroWord    = '0;
  localparam logic       ChipEnable  = 1'b1;
  localparam logic       WriteEnable = 1'b1;
  localparam logic [3:0] AllLanes    = 4'b1111;

  typedef enum logic [1:0] {
    DMEM_IDLE   = 2'd0,
    DMEM_ACCESS = 2'd1,
    DMEM_DONE   = 2'd2
  } dmem_state_e;

  function automatic logic [3:0] lane_bit(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/dmem_ctrl_lane_pick4.sv
// Lowest-set-bit finder over a 4-lane mask; o_any flags a non-empty mask.
module lane_pick4 (
  input  logic [3:0] i_mask,
  output logic [1:0] o_idx,
  output logic       o_any
);

  always_comb begin
    o_idx = 2'd0;
    if (i_mask[0])      o_idx = 2'd0;
    else if (i_mask[1]) o_idx = 2'd1;
    else if (i_mask[2]) o_idx = 2'd2;
    else if (i_mask[3]) o_idx = 2'd3;
  end

  assign o_any = |i_mask;

endmodule

// File: rtl/dmem_ctrl.sv
// Serialises word loads/stores into byte req/ack RAM transactions, stalling the pipe until done.
// Build option: DMEM_LANE_SKIP_EN makes loads fetch only the selected lanes.
//   state       | meaning
//   DMEM_IDLE   | waiting for a request with a non-empty lane mask
//   DMEM_ACCESS | one byte transaction in flight at lane r_idx
//   DMEM_DONE   | presenting the assembled word until the pipe advances
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_ce_i,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [3:0]        mem_sel_i,
  input  logic [31:0]       mem_data_i,
  input  logic              stall_mem_i,
  output logic [31:0]       mem_data_o,
  output logic              stall_req,
  output logic              ram_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  input  logic              ram_ack
);

  dmem_state_e       r_state;
  dmem_state_e       w_next;
  logic [1:0]        r_idx;
  logic [ADDR_W-3:0] r_addr;
  logic              r_we;
  reg_bus_t          r_wdata;
  logic [3:0]        r_rem;
  reg_bus_t          r_rbuf;

  logic [3:0]        w_eff_mask;
  logic              w_start;
  logic [3:0]        w_rem_next;
  logic [3:0]        w_pick_in;
  logic [1:0]        w_pick_idx;
  logic              w_pick_any;
  byte_bus_t         w_wlane;
  reg_bus_t          w_rbuf_upd;
  logic              w_unused_addr_lsb;

  // Address LSBs carry no information: lane choice comes from the select mask.
  assign w_unused_addr_lsb = ^mem_addr_i[1:0];

`ifdef DMEM_LANE_SKIP_EN
  assign w_eff_mask = mem_sel_i;
`else
  assign w_eff_mask = (mem_we_i == WriteEnable) ? mem_sel_i : AllLanes;
`endif

  assign w_start    = (r_state == DMEM_IDLE) && (mem_ce_i == ChipEnable) && (w_eff_mask != 4'b0000);
  assign w_rem_next = r_rem & ~lane_bit(r_idx);

  // One finder serves both the initial capture and the next-lane step after each ack.
  assign w_pick_in  = (r_state == DMEM_IDLE) ? w_eff_mask : w_rem_next;

  lane_pick4 u_pick (
    .i_mask (w_pick_in),
    .o_idx  (w_pick_idx),
    .o_any  (w_pick_any)
  );

  assign w_wlane = r_wdata[{r_idx, 3'b000} +: ByteW];

  always_comb begin
    w_rbuf_upd = r_rbuf;
    w_rbuf_upd[{r_idx, 3'b000} +: ByteW] = ram_rdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= DMEM_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    ram_req    = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = '0;
    ram_wdata  = '0;
    mem_data_o = ZeroWord;
    stall_req  = 1'b0;
    case (r_state)
      DMEM_IDLE: begin
        // Gated by rst so the stall drops the instant reset is applied.
        stall_req = w_start & rst;
        if (w_start) w_next = DMEM_ACCESS;
      end
      DMEM_ACCESS: begin
        ram_req   = 1'b1;
        ram_we    = r_we;
        ram_addr  = {r_addr, r_idx};
        ram_wdata = w_wlane;
        stall_req = 1'b1;
        if (ram_ack && !w_pick_any) w_next = DMEM_DONE;
      end
      DMEM_DONE: begin
        mem_data_o = r_rbuf;
        if (!stall_mem_i) w_next = DMEM_IDLE;
      end
      default: w_next = DMEM_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx   <= 2'd0;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_wdata <= ZeroWord;
      r_rem   <= 4'b0000;
      r_rbuf  <= ZeroWord;
    end else begin
      case (r_state)
        DMEM_IDLE: begin
          if (w_start) begin
            r_idx   <= w_pick_idx;
            r_addr  <= mem_addr_i[ADDR_W-1:2];
            r_we    <= mem_we_i;
            r_wdata <= mem_data_i;
            r_rem   <= w_eff_mask;
            r_rbuf  <= ZeroWord;
          end
        end
        DMEM_ACCESS: begin
          if (ram_ack) begin
            if (!r_we) r_rbuf <= w_rbuf_upd;
            r_rem <= w_rem_next;
            if (w_pick_any) r_idx <= w_pick_idx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Randomised self-checking bench for dmem_ctrl with a transaction-level byte-RAM model.
module tb_dmem_ctrl;

  logic        clk;
  logic        rst;
  logic        mem_ce_i, mem_we_i, stall_mem_i;
  logic [31:0] mem_addr_i, mem_data_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_data_o;
  logic        stall_req, ram_req, ram_we, ram_ack;
  logic [31:0] ram_addr;
  logic [7:0]  ram_wdata, ram_rdata;

  dmem_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
    .mem_sel_i(mem_sel_i), .mem_data_i(mem_data_i), .stall_mem_i(stall_mem_i),
    .mem_data_o(mem_data_o), .stall_req(stall_req),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_ack(ram_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: expected byte-address list, per-byte ack latency, expected word.
  logic [7:0]  mem [logic [31:0]];
  logic [31:0] addr_arr [4];
  int          lat_arr [4];
  int          n_bytes = 0;
  int          exp_sum = 0;
  logic        exp_we = 1'b0;
  logic [31:0] exp_data = '0;
  logic [31:0] exp_word = '0;
  bit          t_active = 1'b0;
  int          gen = 0, seen_gen = 0;
  int          ptr = 0, t_cyc = 0, stall_cnt = 0, cnt = 0;
  bit          new_byte = 1'b1;
  int          n_checks = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    case (a)
      32'h100: return 8'h11;
      32'h101: return 8'h22;
      32'h102: return 8'h33;
      32'h103: return 8'h44;
      32'h302: return 8'h7F;
      32'h303: return 8'h80;
      default: return a[7:0] ^ a[15:8] ^ 8'h3C;
    endcase
  endfunction

  function automatic logic [3:0] eff_mask(input logic we, input logic [3:0] sel);
`ifdef DMEM_LANE_SKIP_EN
    return sel;
`else
    return we ? sel : 4'hF;
`endif
  endfunction

  // Compare process plus RAM responder; outputs sampled at the falling edge.
  always @(negedge clk) begin
    bit busy;
    int lane;
    if (gen != seen_gen) begin
      ptr = 0; t_cyc = 0; stall_cnt = 0; new_byte = 1'b1; seen_gen = gen;
    end
    if (!rst) begin
      chk("rst_req", ram_req, 0);
      chk("rst_stall", stall_req, 0);
      chk("rst_data", mem_data_o, 0);
      chk("rst_addr", ram_addr, 0);
      chk("rst_wdata", ram_wdata, 0);
      ram_ack = 1'b0;
    end else begin
      busy = t_active && (ptr < n_bytes);
      if (!t_active) begin
        chk("idle_stall", stall_req, 0);
        chk("idle_req", ram_req, 0);
        chk("idle_data", mem_data_o, 0);
      end else if (busy) begin
        chk("busy_stall", stall_req, 1);
        chk("busy_data", mem_data_o, 0);
        chk("busy_req", ram_req, (t_cyc != 0));
        if (ram_req) begin
          lane = int'(ram_addr[1:0]);
          chk("ram_addr", ram_addr, addr_arr[ptr]);
          chk("ram_we", ram_we, exp_we);
          if (exp_we) chk("ram_wdata", ram_wdata, exp_data[8*lane +: 8]);
        end
        if (stall_req) stall_cnt++;
      end else begin
        chk("done_stall", stall_req, 0);
        chk("done_req", ram_req, 0);
        chk("done_data", mem_data_o, exp_word);
      end
      if (ram_req && busy) begin
        cnt = new_byte ? 1 : cnt + 1;
        new_byte = 1'b0;
        if (cnt >= lat_arr[ptr]) begin
          ram_ack = 1'b1;
          if (exp_we) begin
            mem[ram_addr] = ram_wdata;
            ram_rdata = 8'($urandom);
          end else begin
            ram_rdata = mem_rd(ram_addr);
          end
          ptr++;
          new_byte = 1'b1;
        end else begin
          ram_ack = 1'b0;
          ram_rdata = 8'($urandom);
        end
      end else begin
        // Stray acks outside a transaction must be ignored.
        ram_ack = ($urandom_range(0, 3) == 0);
        ram_rdata = 8'($urandom);
      end
      if (t_active) t_cyc++;
    end
  end

  task automatic setup_txn(input logic we, input logic [3:0] sel, input logic [31:0] addr,
                           input logic [31:0] data, input int lat_fixed);
    logic [3:0] m;
    logic [1:0] kk;
    int nb;
    m = eff_mask(we, sel);
    nb = 0;
    exp_word = '0;
    exp_sum = 0;
    for (int k = 0; k < 4; k++) begin
      if (m[k]) begin
        kk = k[1:0];
        addr_arr[nb] = {addr[31:2], kk};
        lat_arr[nb] = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 3));
        exp_sum += lat_arr[nb];
        if (!we) exp_word[8*k +: 8] = mem_rd(addr_arr[nb]);
        nb++;
      end
    end
    n_bytes = nb;
    exp_we = we;
    exp_data = data;
    t_active = (nb != 0);
    gen++;
    mem_ce_i = 1'b1; mem_we_i = we; mem_sel_i = sel; mem_addr_i = addr; mem_data_i = data;
  endtask

  task automatic scramble_req();
    mem_ce_i = 1'($urandom); mem_we_i = 1'($urandom); mem_sel_i = 4'($urandom);
    mem_addr_i = $urandom; mem_data_i = $urandom;
  endtask

  task automatic run_txn(input logic we, input logic [3:0] sel, input logic [31:0] addr,
                         input logic [31:0] data, input int lat_fixed, input int hold,
                         input bit noise, output logic [31:0] got, output int stalls);
    int n;
    setup_txn(we, sel, addr, data, lat_fixed);
    got = '0;
    stalls = 0;
    if (n_bytes == 0) begin
      repeat (2) begin @(posedge clk); #1; end
      mem_ce_i = 1'b0;
      return;
    end
    n = 0;
    do begin
      @(posedge clk); #1; n++;
      if (ptr < n_bytes) begin
        stall_mem_i = 1'($urandom);
        if (noise) scramble_req();
      end
    end while (ptr < n_bytes && n < 200);
    chk("txn_complete", (ptr >= n_bytes), 1);
    if (ptr < n_bytes) begin
      rst = 1'b0; t_active = 1'b0; mem_ce_i = 1'b0; gen++;
      @(posedge clk); #1; rst = 1'b1;
      return;
    end
    got = mem_data_o;
    for (int h = 0; h < hold; h++) begin
      stall_mem_i = 1'b1;
      if (noise) scramble_req();
      @(posedge clk); #1;
    end
    stall_mem_i = 1'b0;
    @(posedge clk); #1;
    stalls = stall_cnt;
    t_active = 1'b0;
    mem_ce_i = 1'b0;
    chk("stall_cycles", stalls, exp_sum + 1);
  endtask

  initial begin
    logic [31:0] got;
    int st;
    logic we;
    logic [3:0] sel;
    logic [31:0] addr;
    rst = 1'b0; mem_ce_i = 1'b0; mem_we_i = 1'b0; mem_addr_i = '0; mem_sel_i = '0;
    mem_data_i = '0; stall_mem_i = 1'b0; ram_ack = 1'b0; ram_rdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    run_txn(1'b0, 4'hF, 32'h100, 32'h0, 1, 0, 1'b0, got, st);
    chk("lw_data", got, 32'h44332211);
    chk("lw_stalls", st, 5);

    run_txn(1'b1, 4'b0100, 32'h202, 32'hAAAAAAAA, 3, 0, 1'b0, got, st);
    chk("sb_stalls", st, 4);
    chk("sb_byte", mem_rd(32'h202), 8'hAA);
    chk("sb_only_one_write", mem.num(), 1);
    chk("sb_data", got, 0);

    run_txn(1'b0, 4'b1100, 32'h302, 32'h0, 1, 0, 1'b0, got, st);
`ifdef DMEM_LANE_SKIP_EN
    chk("lh_data", got, 32'h807F0000);
    chk("lh_bytes", n_bytes, 2);
    chk("lh_stalls", st, 3);
`else
    chk("lh_data", got, 32'h807F3E3F);
    chk("lh_bytes", n_bytes, 4);
    chk("lh_stalls", st, 5);
`endif

    run_txn(1'b0, 4'hF, 32'h100, 32'h0, 1, 3, 1'b1, got, st);
    chk("hold_data", got, 32'h44332211);
    chk("hold_stalls", st, 5);

    setup_txn(1'b0, 4'hF, 32'h400, 32'h0, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_mid_pre_ptr", ptr, 1);
    chk("rst_mid_pre_req", ram_req, 1);
    rst = 1'b0; t_active = 1'b0; mem_ce_i = 1'b0; gen++;
    #1;
    chk("rst_mid_req", ram_req, 0);
    chk("rst_mid_stall", stall_req, 0);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    run_txn(1'b0, 4'hF, 32'h100, 32'h0, 1, 0, 1'b0, got, st);
    chk("post_rst_data", got, 32'h44332211);
    chk("post_rst_stalls", st, 5);

    setup_txn(1'b1, 4'b0000, 32'h500, 32'h12345678, 1);
    #1;
    chk("empty_stall", stall_req, 0);
    chk("empty_req", ram_req, 0);
    repeat (2) begin @(posedge clk); #1; end
    chk("empty_data", mem_data_o, 0);
    mem_ce_i = 1'b0;

    for (int i = 0; i < 40; i++) begin
      we = 1'($urandom);
      sel = 4'($urandom);
      addr = 32'h1000 + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3);
      run_txn(we, sel, addr, $urandom, 0, int'($urandom_range(0, 2)), 1'b1, got, st);
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory controller directly downstream of the MEM stage. It consumes the stage's word-wide request: address, write enable, byte selects, store data and chip enable. It serialises the request into byte transactions on a byte-wide req/ack RAM port and holds the pipeline with `stall_req` until all bytes complete. It then returns the assembled 32-bit word on `mem_data_o`, which the MEM stage reads back as its `mem_data_i`.

## Interface
Parameters:
- `ADDR_W`, 32, width of the pipeline-side and RAM-side address.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  reset: asynchronous, active-low (reset while `rst`==0).
- `mem_ce_i`  in  1  request valid (chip enable from MEM stage).
- `mem_we_i`  in  1  1 = store, 0 = load.
- `mem_addr_i`  in  ADDR_W  byte address; bits [1:0] are ignored, because lane choice comes from `mem_sel_i`.
- `mem_sel_i`  in  4  byte-lane selects; bit k means byte k, with byte 0 = data[7:0].
- `mem_data_i`  in  32  store data; lane k = [8k+7:8k].
- `stall_mem_i`  in  1  MEM stage held by the pipeline controller this cycle.
- `mem_data_o`  out  32  load data returned to MEM stage.
- `stall_req`  out  1  stall request to the pipeline controller.
- `ram_req`  out  1  RAM transaction request.
- `ram_we`  out  1  RAM write.
- `ram_addr`  out  ADDR_W  RAM byte address.
- `ram_wdata`  out  8  RAM write byte.
- `ram_rdata`  in  8  RAM read byte; valid in the cycle `ram_ack`=1.
- `ram_ack`  in  1  transaction complete.

## Operation
- **States:** IDLE, ACCESS, DONE. There is also a 2-bit byte index `idx`, plus registered copies of word address, we, store data, remaining-lane mask `rem` and a 32-bit read buffer `rbuf`.
- **Effective mask:**
  - Stores always use `mem_sel_i`.
  - Loads use `mem_sel_i` or 4'b1111, depending on the configuration macro (see Configuration).
- **IDLE:**
  - If `mem_ce_i`=1 and the effective mask is nonzero:
    - capture the request, with `rem` = mask;
    - load `idx` with the lowest set bit of the mask;
    - clear `rbuf`;
    - go to ACCESS.
  - If `mem_ce_i`=1 and the mask is 0: no RAM activity; `mem_data_o`=0 and `stall_req`=0 that cycle.
- **ACCESS:**
  - Drive `ram_req`=1, `ram_addr`={addr[ADDR_W-1:2], `idx`}, `ram_we`=captured we and `ram_wdata`=captured lane `idx`.
  - All four RAM outputs hold steady until `ram_ack` is sampled 1.
  - On ack:
    - for a load, write `ram_rdata` into `rbuf` lane `idx`;
    - clear `rem`[`idx`];
    - if `rem` is now 0, go to DONE; otherwise set `idx` to the next lowest set bit and stay in ACCESS.
  - `ram_req` stays high across back-to-back bytes; there is no idle cycle between them.
- **DONE:**
  - `mem_data_o`=`rbuf` (0 for stores), `stall_req`=0.
  - If `stall_mem_i`=0, go to IDLE. If 1, stay in DONE and keep presenting `rbuf`.
- **Outside DONE:** `mem_data_o`=0.
- **Request inputs while busy:** ignored in ACCESS and DONE. The request still visible in DONE is never re-issued, because IDLE is entered only after the pipeline advances.
- **Never asserted:** `ram_req` is never asserted outside ACCESS.

## Timing
- **Reset values:** `stall_req`=0, `mem_data_o`=0, `ram_req`=0, `ram_we`=0, `ram_addr`=0, `ram_wdata`=0; state IDLE, `rem`=0, `rbuf`=0.
- **Reset mid-transaction:** `ram_req` drops immediately (asynchronous). Any partial store is not rolled back.
- **`stall_req`** = (IDLE and `mem_ce_i` and mask≠0) or ACCESS. It is combinational from `mem_ce_i`/`mem_sel_i` in IDLE.
- **Latency:** a request with N selected bytes, each acked on its A-th request cycle (A≥1), stalls for N·A+1 cycles. The data is presented in the first non-stall (DONE) cycle.
- **ack in the same cycle as reset:** reset wins.
- **`ram_ack` outside ACCESS:** ignored.

## Configuration
- **`DMEM_LANE_SKIP_EN`** defined:
  - loads access only the lanes selected in `mem_sel_i`;
  - unselected lanes of `mem_data_o` read 0.
- **`DMEM_LANE_SKIP_EN`** undefined:
  - loads always read all 4 bytes, with effective mask 4'b1111, so a load always has N=4;
  - `mem_data_o` carries the full word.
- **Stores:** identical in both builds; they never write unselected lanes.

## Structure
- **Shared `defines.v`:**
  - state encodings `DMEM_IDLE`, `DMEM_ACCESS`, `DMEM_DONE`;
  - `ByteBus` (7:0);
  - reuse of the existing `RegBus`, `ZeroWord`, `ChipEnable` and `WriteEnable`.
- **Sub-module `lane_pick4`:** a natural separate block. It is a combinational 4-bit lowest-set-bit finder returning a 2-bit index plus an any-set flag, used both at IDLE capture and at each ack.

## Test plan
- **Word load:** LW, sel=1111, addr 0x100, RAM bytes 11 22 33 44, ack every cycle (A=1) -> 4 `ram_addr` values 0x100–0x103, 5 stall cycles, `mem_data_o`=0x44332211 in DONE.
- **Byte store:** SB, sel=0100, addr 0x202, data 0xAAAAAAAA, A=3 -> one write to 0x202 with `ram_wdata`=0xAA, 4 stall cycles, no other RAM writes.
- **Halfword load:** LH, sel=1100, RAM bytes at 0x302/0x303 = 0x7F/0x80 -> with `DMEM_LANE_SKIP_EN`: 2 accesses, `mem_data_o`=0x807F0000; without it: 4 accesses, full word returned.
- **Held in DONE:** `stall_mem_i`=1 for 3 cycles after DONE -> `mem_data_o` stable, no new `ram_req`, and a single transaction set only.
- **Reset mid-operation:** `rst`=0 during the 2nd byte of an LW -> `ram_req` and `stall_req` drop at once; after release the controller is in IDLE and the next request runs normally.
- **Empty select:** `mem_ce_i`=1 with sel=0000 -> `stall_req`=0, no `ram_req`, `mem_data_o`=0.
